ul4_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 4-bit logic unit `ul4`. It accepts operation requests (A, B, S) from two independent clients over valid/ready handshakes and grants the single `ul4` instance to one client at a time. It registers the result and returns it over a per-client response handshake. It sits between the client blocks and the `ul4` datapath and counts completed operations.

---
 rtl/ul4_arb_pkg.sv | 25 ++
 rtl/ul4_arb_if.sv | 28 ++
 rtl/ul4_arb_ul4.sv | 21 ++
 rtl/ul4_arb.sv | 124 ++++++++++++
 tb/tb_ul4_arb.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ul4_arb_pkg.sv
// Shared types and constants for the ul4 two-client arbiter.
// The state encoding, client count and operand width live here so every file agrees on them.
package ul4_arb_pkg;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned UL4_W = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef logic [UL4_W-1:0] opnd_t;
    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NREQ-1:0] onehot(input logic id);
        logic [NREQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ul4_arb_if.sv
// Client-facing request/response bundle of the ul4 arbiter.
// master = client side, slave = arbiter side.
interface ul4_arb_if #(
    parameter int unsigned CNT_W = 8
);

    logic [ul4_arb_pkg::NREQ-1:0]                     req_valid;
    logic [ul4_arb_pkg::NREQ-1:0]                     req_ready;
    logic [ul4_arb_pkg::NREQ*ul4_arb_pkg::UL4_W-1:0]  req_a;
    logic [ul4_arb_pkg::NREQ*ul4_arb_pkg::UL4_W-1:0]  req_b;
    logic [ul4_arb_pkg::NREQ*ul4_arb_pkg::SEL_W-1:0]  req_s;
    logic [ul4_arb_pkg::NREQ-1:0]                     rsp_valid;
    logic [ul4_arb_pkg::NREQ-1:0]                     rsp_ready;
    logic [ul4_arb_pkg::UL4_W-1:0]                    rsp_data;
    logic                                             busy;
    logic [CNT_W-1:0]                                 op_count;

    modport master (
        output req_valid, req_a, req_b, req_s, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_s, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy, op_count
    );

endinterface

// File: rtl/ul4_arb_ul4.sv
// ul4: 4-bit logic unit. S selects AND, OR, XOR of A and B, or NOT A.
module ul4
    import ul4_arb_pkg::*;
(
    input  opnd_t a_i,
    input  opnd_t b_i,
    input  sel_t  s_i,
    output opnd_t y_o
);

    always_comb begin
        y_o = '0;
        unique case (s_i)
            2'b00: y_o = a_i & b_i;
            2'b01: y_o = a_i | b_i;
            2'b10: y_o = a_i ^ b_i;
            2'b11: y_o = ~a_i;
        endcase
    end

endmodule

// File: rtl/ul4_arb.sv
// Two-client arbiter/sequencer in front of a single ul4 instance.
// Define UL4_ARB_RR_EN for round-robin tie-breaking; otherwise client 0 has fixed priority.
module ul4_arb
    import ul4_arb_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ul4_arb_if.slave   bus
);

    state_e            state_q, state_d;
    opnd_t             a_q, b_q, res_q;
    sel_t              s_q;
    logic              owner_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant_id;
    logic [NREQ-1:0]   grant;
    logic              accept;
    logic              rsp_done;
    opnd_t             ul4_y;

    // Arbitration: grant_id is only meaningful when at least one request is valid.
`ifdef UL4_ARB_RR_EN
    logic prio_q;

    assign grant_id = (&bus.req_valid) ? prio_q : bus.req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (rsp_done) begin
            prio_q <= ~owner_q;
        end
    end
`else
    assign grant_id = ~bus.req_valid[0];
`endif

    always_comb begin
        grant = '0;
        if (state_q == ST_IDLE && |bus.req_valid) begin
            grant = onehot(grant_id);
        end
    end

    assign accept   = |grant;
    assign rsp_done = (state_q == ST_RESP) && bus.rsp_ready[owner_q];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)   state_d = ST_EXEC;
            ST_EXEC:               state_d = ST_RESP;
            ST_RESP: if (rsp_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.rsp_valid = '0;
        bus.busy      = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            bus.rsp_valid = onehot(owner_q);
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_data  = res_q;
    assign bus.op_count  = cnt_q;

    // Operand capture, result register and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            owner_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                a_q     <= bus.req_a[grant_id*UL4_W +: UL4_W];
                b_q     <= bus.req_b[grant_id*UL4_W +: UL4_W];
                s_q     <= bus.req_s[grant_id*SEL_W +: SEL_W];
                owner_q <= grant_id;
            end
            if (state_q == ST_EXEC) begin
                res_q <= ul4_y;
            end
            if (rsp_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    ul4 u_ul4 (
        .a_i (a_q),
        .b_i (b_q),
        .s_i (s_q),
        .y_o (ul4_y)
    );

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != ST_IDLE) |-> (bus.req_ready == '0));
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid != '0 && !rsp_done) |=> $stable(bus.rsp_data));

endmodule

// File: tb/tb_ul4_arb.sv
// Self-checking bench for ul4_arb: vector table, directed corner cases, randomized model check.
module tb_ul4_arb;
    import ul4_arb_pkg::*;

    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ul4_arb_if #(.CNT_W(CW)) bus ();

    ul4_arb #(.CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    typedef struct {
        int         client;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] s;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[8];

    // Random-model state
    logic [1:0] pend;
    logic [3:0] pa[2];
    logic [3:0] pb[2];
    logic [1:0] ps[2];
    int         last_done;
    bit         infl;
    int         age;
    int         own;
    logic [3:0] edata;
    logic [1:0] er;
    logic [1:0] ev;
    int         pr;
    int         w;
    bit         hs;

    int         grants[4];
    int         ngr;
    logic [3:0] held;

    function automatic logic [3:0] ref_ul4(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_s     = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic set_req(input int c, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] s);
        bus.req_valid[c]     = 1'b1;
        bus.req_a[c*4 +: 4]  = a;
        bus.req_b[c*4 +: 4]  = b;
        bus.req_s[c*2 +: 2]  = s;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    // One complete operation with rsp_ready held high; checks the E0/E1/E2 timing.
    task automatic run_op(input int c, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] s, input logic [3:0] y);
        @(negedge clk);
        bus.req_valid = '0;
        set_req(c, a, b, s);
        bus.rsp_ready = 2'b11;
        #1;
        check("op_req_ready", bus.req_ready, 32'(1 << c));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("op_exec_busy", bus.busy, 1);
        check("op_exec_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        #1;
        check("op_rsp_valid", bus.rsp_valid, 32'(1 << c));
        check("op_rsp_data", bus.rsp_data, y);
        @(negedge clk);
        #1;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        check("op_done_rsp_valid", bus.rsp_valid, 0);
        check("op_done_busy", bus.busy, 0);
        check("op_count", bus.op_count, exp_cnt);
    endtask

    initial begin
        vecs[0] = '{0, 4'b1010, 4'b0110, 2'b00, 4'b0010};
        vecs[1] = '{1, 4'b1010, 4'b0110, 2'b01, 4'b1110};
        vecs[2] = '{0, 4'b1010, 4'b0110, 2'b10, 4'b1100};
        vecs[3] = '{1, 4'b1010, 4'b0110, 2'b11, 4'b0101};
        vecs[4] = '{0, 4'hF,    4'h0,    2'b00, 4'h0};
        vecs[5] = '{1, 4'h3,    4'hC,    2'b01, 4'hF};
        vecs[6] = '{0, 4'hF,    4'hF,    2'b10, 4'h0};
        vecs[7] = '{1, 4'h0,    4'h9,    2'b11, 4'hF};

        // Reset values
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_op_count", bus.op_count, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        set_req(0, 4'h1, 4'h1, 2'b00);
        set_req(1, 4'h2, 4'h2, 2'b00);
        #1;
        check("rst_first_winner", bus.req_ready, 2'b01);
        bus.req_valid = '0;
        #1;
        check("rst_no_req_ready", bus.req_ready, 0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].client, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].y);
        end

        // Fairness with both clients requesting continuously
        do_reset();
        @(negedge clk);
        set_req(0, 4'h5, 4'h3, 2'b00);
        set_req(1, 4'h6, 4'h3, 2'b01);
        bus.rsp_ready = 2'b11;
        ngr = 0;
        for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                grants[ngr] = bus.req_ready[1] ? 1 : 0;
                ngr++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        check("fair_grant_count", ngr, 4);
        for (int i = 0; i < ngr; i++) begin
`ifdef UL4_ARB_RR_EN
            check("fair_grant_rr", grants[i], i % 2);
`else
            check("fair_grant_fixed", grants[i], 0);
`endif
        end
        repeat (3) @(negedge clk);
        exp_cnt = ngr;
        #1;
        check("fair_op_count", bus.op_count, exp_cnt);

        // Response stall on client 1, with rsp_ready[0] high and client 0 waiting
        @(negedge clk);
        clear_inputs();
        set_req(1, 4'h9, 4'h5, 2'b01);
        #1;
        check("stall_accept", bus.req_ready, 2'b10);
        @(negedge clk);
        bus.req_valid = 2'b00;
        set_req(0, 4'h7, 4'h7, 2'b10);
        bus.rsp_ready = 2'b01;
        @(negedge clk);
        held = ref_ul4(4'h9, 4'h5, 2'b01);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_rsp_valid", bus.rsp_valid, 2'b10);
            check("stall_rsp_data", bus.rsp_data, held);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_op_count", bus.op_count, exp_cnt);
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        #1;
        exp_cnt++;
        check("stall_release_valid", bus.rsp_valid, 0);
        check("stall_release_count", bus.op_count, exp_cnt);

        // Counter wrap over 256 operations
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [1:0] rs;
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 2'($urandom);
            run_op(i % 2, ra, rb, rs, ref_ul4(ra, rb, rs));
        end
        check("wrap_to_zero", bus.op_count, 0);

        // Reset while a response is pending
        do_reset();
        @(negedge clk);
        set_req(0, 4'h5, 4'h3, 2'b10);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        check("mid_rsp_pending", bus.rsp_valid, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_rsp_valid", bus.rsp_valid, 0);
        check("mid_async_busy", bus.busy, 0);
        check("mid_async_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_no_rsp", bus.rsp_valid, 0);
            check("mid_no_count", bus.op_count, 0);
        end

        // Randomized traffic against a transaction-level model
        do_reset();
        pend      = '0;
        last_done = -1;
        infl      = 0;
        age       = 0;
        own       = 0;
        edata     = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = 4'($urandom);
                    pb[i]   = 4'($urandom);
                    ps[i]   = 2'($urandom);
                end
                bus.req_a[i*4 +: 4] = pa[i];
                bus.req_b[i*4 +: 4] = pb[i];
                bus.req_s[i*2 +: 2] = ps[i];
            end
            bus.req_valid = pend;
            bus.rsp_ready = 2'($urandom_range(0, 3));
            #1;
`ifdef UL4_ARB_RR_EN
            pr = (last_done < 0) ? 0 : 1 - last_done;
`else
            pr = 0;
`endif
            er = '0;
            if (!infl && pend != 2'b00) begin
                w  = (pend == 2'b11) ? pr : (pend[1] ? 1 : 0);
                er = 2'(1 << w);
            end
            ev = (infl && age >= 1) ? 2'(1 << own) : 2'b00;
            check("rnd_req_ready", bus.req_ready, er);
            check("rnd_rsp_valid", bus.rsp_valid, ev);
            check("rnd_busy", bus.busy, infl);
            check("rnd_op_count", bus.op_count, exp_cnt);
            if (ev != 2'b00) begin
                check("rnd_rsp_data", bus.rsp_data, edata);
            end
            hs = (ev != 2'b00) && bus.rsp_ready[own];
            @(posedge clk);
            if (hs) begin
                infl      = 0;
                exp_cnt   = (exp_cnt + 1) % (1 << CW);
                last_done = own;
            end
            if (er != 2'b00) begin
                w       = er[1] ? 1 : 0;
                infl    = 1;
                age     = 0;
                own     = w;
                edata   = ref_ul4(pa[w], pb[w], ps[w]);
                pend[w] = 1'b0;
            end else if (infl) begin
                age++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
